// File: rtl/data_mem_mmio.sv
// Data memory and memory-mapped I/O: general RAM, screen shadow with a write-forwarding
// FIFO toward the display controller, and a keyboard register. Reads are combinational.
module data_mem_mmio #(
    parameter int RAM_WORDS  = 16384,
    parameter int SCR_WORDS  = 8192,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [14:0] addr_M,
    input  logic        writeM,
    input  logic [15:0] outM,
    output logic [15:0] MReg,
    input  logic        kbd_valid,
    input  logic [15:0] kbd_code,
    output logic        vid_valid,
    input  logic        vid_ready,
    output logic [12:0] vid_addr,
    output logic [15:0] vid_data,
    output logic        ovf
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int SCR_AW = $clog2(SCR_WORDS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {REG_RAM, REG_SCR, REG_KBD, REG_NONE} region_t;

    region_t           region;
    logic [15:0]       ram [RAM_WORDS];
    logic [15:0]       scr [SCR_WORDS];
    logic [12:0]       fifo_addr [FIFO_DEPTH];
    logic [15:0]       fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [15:0]       kbd_reg;
    logic              push_req, push, pop, full, drop;

    always_comb begin
        if (addr_M < 15'h4000)       region = REG_RAM;
        else if (addr_M < 15'h6000)  region = REG_SCR;
        else if (addr_M == 15'h6000) region = REG_KBD;
        else                         region = REG_NONE;
    end

    always_comb begin
        MReg = 16'h0000;
        unique case (region)
            REG_RAM:  MReg = ram[addr_M[RAM_AW-1:0]];
            REG_SCR:  MReg = scr[addr_M[SCR_AW-1:0]];
            REG_KBD:  MReg = kbd_reg;
            REG_NONE: MReg = 16'h0000;
        endcase
    end

    // A simultaneous pop frees the head slot, so a push into a full FIFO still lands.
    assign full     = (count == FULL_CNT);
    assign pop      = vid_valid & vid_ready;
    assign push_req = ~rst & writeM & (region == REG_SCR);
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    assign vid_valid = (count != '0);
    assign vid_addr  = fifo_addr[rd_ptr];
    assign vid_data  = fifo_data[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst && writeM && region == REG_RAM)
            ram[addr_M[RAM_AW-1:0]] <= outM;
        if (!rst && writeM && region == REG_SCR)
            scr[addr_M[SCR_AW-1:0]] <= outM;
        if (push) begin
            fifo_addr[wr_ptr] <= addr_M[12:0];
            fifo_data[wr_ptr] <= outM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            kbd_reg <= 16'h0000;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
            if (drop)
                ovf <= 1'b1;
            // A fresh keycode beats the software acknowledge in the same cycle.
            if (kbd_valid)
                kbd_reg <= kbd_code;
            else if (writeM && region == REG_KBD)
                kbd_reg <= 16'h0000;
        end
    end
endmodule

// File: tb/tb_data_mem_mmio.sv
// Bench for data_mem_mmio: queue/array reference model checked every cycle, plus directed literals.
module tb_data_mem_mmio;
    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] addr_M;
    logic        writeM;
    logic [15:0] outM;
    logic [15:0] MReg;
    logic        kbd_valid;
    logic [15:0] kbd_code;
    logic        vid_valid;
    logic        vid_ready;
    logic [12:0] vid_addr;
    logic [15:0] vid_data;
    logic        ovf;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 0;

    logic [15:0] m_ram [int];
    logic [15:0] m_scr [int];
    logic [28:0] m_q [$];
    logic        m_ovf;
    logic [15:0] m_kbd;

    data_mem_mmio dut (
        .clk(clk), .rst(rst), .addr_M(addr_M), .writeM(writeM), .outM(outM), .MReg(MReg),
        .kbd_valid(kbd_valid), .kbd_code(kbd_code), .vid_valid(vid_valid), .vid_ready(vid_ready),
        .vid_addr(vid_addr), .vid_data(vid_data), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected read value; returns 0 when the word was never written (contents unknown).
    function automatic bit model_read(input logic [14:0] a, output logic [15:0] v);
        v = 16'h0000;
        if (a < 15'h4000) begin
            if (!m_ram.exists(int'(a))) return 0;
            v = m_ram[int'(a)];
        end else if (a < 15'h6000) begin
            if (!m_scr.exists(int'(a[12:0]))) return 0;
            v = m_scr[int'(a[12:0])];
        end else if (a == 15'h6000) begin
            v = m_kbd;
        end
        return 1;
    endfunction

    // Advance the model with the inputs present at this edge, then settle past it.
    task automatic step();
        bit pop;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_kbd = 16'h0000;
        end else begin
            pop = (m_q.size() != 0) && vid_ready;
            if (pop) void'(m_q.pop_front());
            if (writeM) begin
                if (addr_M < 15'h4000) m_ram[int'(addr_M)] = outM;
                else if (addr_M < 15'h6000) begin
                    m_scr[int'(addr_M[12:0])] = outM;
                    if (m_q.size() < 4) m_q.push_back({addr_M[12:0], outM});
                    else m_ovf = 1'b1;
                end else if (addr_M == 15'h6000) m_kbd = 16'h0000;
            end
            if (kbd_valid) m_kbd = kbd_code;
        end
        #1;
    endtask

    always @(negedge clk) begin
        logic [15:0] e;
        if (run_cmp) begin
            chk("vid_valid", {31'd0, vid_valid}, {31'd0, m_q.size() != 0});
            chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
            if (m_q.size() != 0) begin
                chk("vid_addr", {19'd0, vid_addr}, {19'd0, m_q[0][28:16]});
                chk("vid_data", {16'd0, vid_data}, {16'd0, m_q[0][15:0]});
            end
            if (model_read(addr_M, e))
                chk("MReg", {16'd0, MReg}, {16'd0, e});
        end
    end

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        addr_M = a; outM = d; writeM = 1'b1;
        step();
        writeM = 1'b0;
    endtask

    initial begin
        rst = 1'b1; addr_M = '0; writeM = 1'b0; outM = '0;
        kbd_valid = 1'b0; kbd_code = '0; vid_ready = 1'b0;
        m_ovf = 1'b0; m_kbd = '0;
        step();
        step();
        run_cmp = 1;
        rst = 1'b0;
        addr_M = 15'h6000; #1;
        chk("rst vid_valid", {31'd0, vid_valid}, 32'd0);
        chk("rst ovf", {31'd0, ovf}, 32'd0);
        chk("rst kbd", {16'd0, MReg}, 32'h0000);

        // RAM write/read, same-cycle read-old, NONE region
        wr(15'h0005, 16'h1111);
        addr_M = 15'h0005; outM = 16'h1234; writeM = 1'b1; #1;
        chk("ram same-cycle old", {16'd0, MReg}, 32'h1111);
        step();
        writeM = 1'b0; #1;
        chk("ram read new", {16'd0, MReg}, 32'h1234);
        addr_M = 15'h7FFF; outM = 16'hBEEF; writeM = 1'b1; #1;
        chk("none read", {16'd0, MReg}, 32'h0000);
        step();
        writeM = 1'b0;

        // Screen push + handshake
        vid_ready = 1'b0;
        wr(15'h4010, 16'hAAAA);
        #1;
        chk("scr vid_valid", {31'd0, vid_valid}, 32'd1);
        chk("scr vid_addr", {19'd0, vid_addr}, 32'h010);
        chk("scr vid_data", {16'd0, vid_data}, 32'hAAAA);
        chk("scr shadow", {16'd0, MReg}, 32'hAAAA);
        vid_ready = 1'b1;
        step();
        vid_ready = 1'b0; #1;
        chk("scr popped", {31'd0, vid_valid}, 32'd0);

        // Full FIFO with simultaneous push and pop
        for (int i = 1; i <= 4; i++) wr(15'h4200 + 15'(i), 16'(i));
        vid_ready = 1'b1;
        wr(15'h4209, 16'd9);
        vid_ready = 1'b0; #1;
        chk("pushpop ovf", {31'd0, ovf}, 32'd0);
        chk("pushpop head", {16'd0, vid_data}, 32'd2);
        vid_ready = 1'b1;
        chk("drain a", {16'd0, vid_data}, 32'd2); step();
        chk("drain b", {16'd0, vid_data}, 32'd3); step();
        chk("drain c", {16'd0, vid_data}, 32'd4); step();
        chk("drain d", {16'd0, vid_data}, 32'd9); step();
        chk("drain empty", {31'd0, vid_valid}, 32'd0);
        vid_ready = 1'b0;

        // Overflow
        for (int i = 1; i <= 5; i++) wr(15'h4100 + 15'(i), 16'(i));
        addr_M = 15'h4105; #1;
        chk("ovf set", {31'd0, ovf}, 32'd1);
        chk("ovf shadow5", {16'd0, MReg}, 32'd5);
        vid_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovf drain", {16'd0, vid_data}, 32'(i));
            step();
        end
        chk("ovf drained", {31'd0, vid_valid}, 32'd0);
        chk("ovf sticky", {31'd0, ovf}, 32'd1);
        vid_ready = 1'b0;

        // Keyboard
        kbd_valid = 1'b1; kbd_code = 16'h0041; addr_M = 15'h6000;
        step();
        kbd_valid = 1'b0; #1;
        chk("kbd load", {16'd0, MReg}, 32'h0041);
        wr(15'h6000, 16'hFFFF); #1;
        chk("kbd ack", {16'd0, MReg}, 32'h0000);
        kbd_valid = 1'b1; kbd_code = 16'h0042;
        wr(15'h6000, 16'h1234);
        kbd_valid = 1'b0; #1;
        chk("kbd wins", {16'd0, MReg}, 32'h0042);
        step();
        chk("kbd read keeps", {16'd0, MReg}, 32'h0042);

        // Reset mid-operation with pending entries; reset-cycle writes are discarded
        for (int i = 1; i <= 3; i++) wr(15'h4300 + 15'(i), 16'(16'h100 + i));
        rst = 1'b1; kbd_valid = 1'b1; kbd_code = 16'h0055;
        wr(15'h0005, 16'hDEAD);
        rst = 1'b0; kbd_valid = 1'b0;
        addr_M = 15'h6000; #1;
        chk("rst2 vid_valid", {31'd0, vid_valid}, 32'd0);
        chk("rst2 ovf", {31'd0, ovf}, 32'd0);
        chk("rst2 kbd", {16'd0, MReg}, 32'h0000);
        addr_M = 15'h0005; #1;
        chk("rst2 ram kept", {16'd0, MReg}, 32'h1234);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
